// File: rtl/rx_window_strobe_pkg.sv
// Shared types and constants for the receive-window strobe generator.
package rx_window_strobe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_PERIOD      = 1;

  // debugbus layout: {state[1:0], gate_s, strobe, gate_enable, trunc_flag, period_cnt[7:0], 2'b0}
  localparam int DBG_STATE_LSB = 14;
  localparam int DBG_GATE_S    = 13;
  localparam int DBG_STROBE    = 12;
  localparam int DBG_GATE_EN   = 11;
  localparam int DBG_TRUNC     = 10;
  localparam int DBG_PCNT_LSB  = 2;

endpackage

// File: rtl/rx_window_strobe_gate_sync.sv
// Multi-flop synchronizer for the asynchronous receive gate, with rising-edge detect.
module rx_window_strobe_gate_sync
  import rx_window_strobe_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_in,
  output logic gate_s,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              gate_prev;

  // NOTE: non-blocking assignments so every flop samples its pre-edge input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      gate_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[STAGES-2:0], gate_in};
      gate_prev <= sync_q[STAGES-1];
    end
  end

  assign gate_s = sync_q[STAGES-1];
  assign rise   = gate_s & ~gate_prev;

endmodule

// File: rtl/rx_window_strobe.sv
// Turns the raw receive-window gate into decimated sample strobes and a gate_enable
// for the FIFO block, with per-window sample and window counters.
module rx_window_strobe
  import rx_window_strobe_pkg::*;
#(
  parameter int DECIM_W     = 8,
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gate_in,
  input  logic               enable,
  input  logic [DECIM_W-1:0] decim,
  input  logic [3:0]         channels,
  input  logic [COUNT_W-1:0] max_samples,
  input  logic               clear_status,
  output logic               strobe,
  output logic               gate_enable,
  output logic [COUNT_W-1:0] sample_count,
  output logic [15:0]        window_count,
  output logic               trunc_flag,
  output logic [15:0]        debugbus
);

  // Period register must hold both decim and the channel count.
  localparam int PW = (DECIM_W > 4) ? DECIM_W : 4;

  logic gate_s;
  logic rise;

  rx_window_strobe_gate_sync #(
    .STAGES (SYNC_STAGES)
  ) u_gate_sync (
    .clk     (clk),
    .reset   (reset),
    .gate_in (gate_in),
    .gate_s  (gate_s),
    .rise    (rise)
  );

  state_t            state, state_d;
  logic [PW-1:0]     period_q, period_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [PW-1:0]     decim_ext, ch_ext, p_new;
  logic [COUNT_W-1:0] count_d, cnt_inc;
  logic [15:0]       wcount_d;
  logic              trunc_d;
  logic              strobe_d, gate_en_d;

  always_comb begin
    decim_ext = PW'(decim);
    ch_ext    = (channels == 4'd0) ? PW'(1) : PW'(channels);
    p_new     = (decim_ext > ch_ext) ? decim_ext : ch_ext;
    if (p_new < PW'(MIN_PERIOD)) p_new = PW'(MIN_PERIOD);
  end

  assign cnt_inc = (sample_count == {COUNT_W{1'b1}}) ? sample_count
                                                     : sample_count + COUNT_W'(1);

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state;
    period_d = period_q;
    pcnt_d   = pcnt_q;
    count_d  = sample_count;
    wcount_d = window_count;
    trunc_d  = trunc_flag;
    if (clear_status) trunc_d = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (rise && enable) begin
          state_d  = ST_ACTIVE;
          period_d = p_new;
          pcnt_d   = '0;
          count_d  = '0;
          wcount_d = window_count + 16'd1;
        end
      end
      ST_ACTIVE: begin
        pcnt_d = (pcnt_q >= period_q - PW'(1)) ? '0 : pcnt_q + PW'(1);
        if (strobe) count_d = cnt_inc;
        // Gate loss takes priority over truncation; the strobe still counts.
        if (!gate_s) begin
          state_d = ST_IDLE;
          pcnt_d  = '0;
        end else if (strobe && (max_samples != '0) && (cnt_inc == max_samples)) begin
          state_d = ST_DONE;
          pcnt_d  = '0;
          trunc_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!gate_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with state.
  assign strobe_d  = (state_d == ST_ACTIVE) && (pcnt_d == '0);
  assign gate_en_d = (state_d == ST_ACTIVE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      period_q     <= PW'(MIN_PERIOD);
      pcnt_q       <= '0;
      sample_count <= '0;
      window_count <= '0;
      trunc_flag   <= 1'b0;
      strobe       <= 1'b0;
      gate_enable  <= 1'b0;
    end else begin
      state        <= state_d;
      period_q     <= period_d;
      pcnt_q       <= pcnt_d;
      sample_count <= count_d;
      window_count <= wcount_d;
      trunc_flag   <= trunc_d;
      strobe       <= strobe_d;
      gate_enable  <= gate_en_d;
    end
  end

  logic [7:0] pcnt_dbg;

  if (PW >= 8) begin : g_dbg_trunc
    assign pcnt_dbg = pcnt_q[7:0];
  end else begin : g_dbg_ext
    assign pcnt_dbg = 8'(pcnt_q);
  end

  always_comb begin
    debugbus                       = '0;
    debugbus[DBG_STATE_LSB +: 2]   = state;
    debugbus[DBG_GATE_S]           = gate_s;
    debugbus[DBG_STROBE]           = strobe;
    debugbus[DBG_GATE_EN]          = gate_enable;
    debugbus[DBG_TRUNC]            = trunc_flag;
    debugbus[DBG_PCNT_LSB +: 8]    = pcnt_dbg;
  end

endmodule

// File: tb/tb_rx_window_strobe.sv
// Directed bench for rx_window_strobe: window timing, period clamp, truncation, reset.
module tb_rx_window_strobe;

  logic        clk;
  logic        reset;
  logic        gate_in;
  logic        enable;
  logic [7:0]  decim;
  logic [3:0]  channels;
  logic [15:0] max_samples;
  logic        clear_status;
  logic        strobe;
  logic        gate_enable;
  logic [15:0] sample_count;
  logic [15:0] window_count;
  logic        trunc_flag;
  logic [15:0] debugbus;

  int n_cmp = 0;
  int n_err = 0;

  // Per-window observations, filled by run_window.
  int stb_q[$];
  int ge_cnt, ge_first, ge_last, stb_outside, done_cnt, last_stb;

  rx_window_strobe dut (
    .clk          (clk),
    .reset        (reset),
    .gate_in      (gate_in),
    .enable       (enable),
    .decim        (decim),
    .channels     (channels),
    .max_samples  (max_samples),
    .clear_status (clear_status),
    .strobe       (strobe),
    .gate_enable  (gate_enable),
    .sample_count (sample_count),
    .window_count (window_count),
    .trunc_flag   (trunc_flag),
    .debugbus     (debugbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gate high for `len` clocks; tick i is observed 1ns after the i-th edge after the gate rise.
  task automatic run_window(input int len, input int clr_at, input int chg_at, input logic [7:0] chg_decim);
    stb_q.delete();
    ge_cnt = 0; ge_first = -1; ge_last = -1; stb_outside = 0; done_cnt = 0; last_stb = -1;
    gate_in = 1'b1;
    for (int i = 1; i <= len + 8; i++) begin
      tick();
      if (strobe) begin stb_q.push_back(i); last_stb = i; end
      if (strobe && !gate_enable) stb_outside++;
      if (gate_enable) begin
        ge_cnt++;
        if (ge_first < 0) ge_first = i;
        ge_last = i;
      end
      if (debugbus[15:14] == 2'd2) done_cnt++;
      if (i == len) gate_in = 1'b0;
      clear_status = (i == clr_at);
      if (i == chg_at) decim = chg_decim;
    end
    clear_status = 1'b0;
  endtask

  function automatic int bad_gaps(input int p);
    int b = 0;
    for (int k = 1; k < stb_q.size(); k++)
      if (stb_q[k] - stb_q[k-1] != p) b++;
    return b;
  endfunction

  task automatic test_reset();
    reset = 1'b0; gate_in = 1'b0; enable = 1'b1; decim = 8'd10; channels = 4'd4;
    max_samples = 16'd0; clear_status = 1'b0;
    repeat (3) tick();
    n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL rst_strobe: got %b want 0", strobe); end
    n_cmp++; if (gate_enable !== 1'b0) begin n_err++; $display("FAIL rst_gate_enable: got %b want 0", gate_enable); end
    n_cmp++; if (sample_count !== 16'd0) begin n_err++; $display("FAIL rst_sample_count: got %0d want 0", sample_count); end
    n_cmp++; if (window_count !== 16'd0) begin n_err++; $display("FAIL rst_window_count: got %0d want 0", window_count); end
    n_cmp++; if (trunc_flag !== 1'b0) begin n_err++; $display("FAIL rst_trunc: got %b want 0", trunc_flag); end
    n_cmp++; if (debugbus !== 16'h0000) begin n_err++; $display("FAIL rst_debugbus: got %h want 0000", debugbus); end
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    decim = 8'd10; channels = 4'd4; max_samples = 16'd0;
    run_window(100, -1, -1, 8'd0);
    n_cmp++; if (stb_q.size() != 10) begin n_err++; $display("FAIL basic_nstrobe: got %0d want 10", stb_q.size()); end
    n_cmp++; if (stb_q.size() == 0 || stb_q[0] != 3) begin n_err++; $display("FAIL basic_first_strobe: got %0d want 3", (stb_q.size() == 0) ? -1 : stb_q[0]); end
    n_cmp++; if (bad_gaps(10) != 0) begin n_err++; $display("FAIL basic_period: got %0d bad gaps want 0", bad_gaps(10)); end
    n_cmp++; if (stb_outside != 0) begin n_err++; $display("FAIL basic_strobe_outside: got %0d want 0", stb_outside); end
    n_cmp++; if (sample_count !== 16'd10) begin n_err++; $display("FAIL basic_sample_count: got %0d want 10", sample_count); end
    n_cmp++; if (window_count !== 16'd1) begin n_err++; $display("FAIL basic_window_count: got %0d want 1", window_count); end
    n_cmp++; if (ge_cnt != 100) begin n_err++; $display("FAIL basic_ge_span: got %0d want 100", ge_cnt); end
    n_cmp++; if (ge_first != 3) begin n_err++; $display("FAIL basic_ge_first: got %0d want 3", ge_first); end
  endtask

  task automatic test_period_clamp();
    decim = 8'd2; channels = 4'd8; max_samples = 16'd0;
    run_window(50, -1, -1, 8'd0);
    n_cmp++; if (stb_q.size() != 7) begin n_err++; $display("FAIL clamp8_nstrobe: got %0d want 7", stb_q.size()); end
    n_cmp++; if (bad_gaps(8) != 0) begin n_err++; $display("FAIL clamp8_period: got %0d bad gaps want 0", bad_gaps(8)); end
    n_cmp++; if (sample_count !== 16'd7) begin n_err++; $display("FAIL clamp8_sample_count: got %0d want 7", sample_count); end
    n_cmp++; if (window_count !== 16'd2) begin n_err++; $display("FAIL clamp8_window_count: got %0d want 2", window_count); end
    decim = 8'd0; channels = 4'd0;
    run_window(20, -1, -1, 8'd0);
    n_cmp++; if (stb_q.size() != 20) begin n_err++; $display("FAIL clamp1_nstrobe: got %0d want 20", stb_q.size()); end
    n_cmp++; if (bad_gaps(1) != 0) begin n_err++; $display("FAIL clamp1_period: got %0d bad gaps want 0", bad_gaps(1)); end
    n_cmp++; if (ge_cnt != 20) begin n_err++; $display("FAIL clamp1_ge_span: got %0d want 20", ge_cnt); end
    n_cmp++; if (sample_count !== 16'd20) begin n_err++; $display("FAIL clamp1_sample_count: got %0d want 20", sample_count); end
    n_cmp++; if (window_count !== 16'd3) begin n_err++; $display("FAIL clamp1_window_count: got %0d want 3", window_count); end
  endtask

  task automatic test_truncation();
    decim = 8'd4; channels = 4'd1; max_samples = 16'd5;
    run_window(100, -1, -1, 8'd0);
    n_cmp++; if (stb_q.size() != 5) begin n_err++; $display("FAIL trunc_nstrobe: got %0d want 5", stb_q.size()); end
    n_cmp++; if (last_stb != 19) begin n_err++; $display("FAIL trunc_last_strobe: got %0d want 19", last_stb); end
    n_cmp++; if (ge_last != 19) begin n_err++; $display("FAIL trunc_ge_last: got %0d want 19", ge_last); end
    n_cmp++; if (ge_cnt != 17) begin n_err++; $display("FAIL trunc_ge_span: got %0d want 17", ge_cnt); end
    n_cmp++; if (done_cnt != 83) begin n_err++; $display("FAIL trunc_done_span: got %0d want 83", done_cnt); end
    n_cmp++; if (sample_count !== 16'd5) begin n_err++; $display("FAIL trunc_sample_count: got %0d want 5", sample_count); end
    n_cmp++; if (window_count !== 16'd4) begin n_err++; $display("FAIL trunc_window_count: got %0d want 4", window_count); end
    repeat (5) tick();
    n_cmp++; if (trunc_flag !== 1'b1) begin n_err++; $display("FAIL trunc_flag_sticky: got %b want 1", trunc_flag); end
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    n_cmp++; if (trunc_flag !== 1'b0) begin n_err++; $display("FAIL trunc_flag_clear: got %b want 0", trunc_flag); end
    // Clear lands on the same edge that sets the flag.
    run_window(100, 19, -1, 8'd0);
    n_cmp++; if (trunc_flag !== 1'b1) begin n_err++; $display("FAIL trunc_set_wins: got %b want 1", trunc_flag); end
    n_cmp++; if (stb_q.size() != 5) begin n_err++; $display("FAIL trunc2_nstrobe: got %0d want 5", stb_q.size()); end
    clear_status = 1'b1; tick(); clear_status = 1'b0;
    n_cmp++; if (trunc_flag !== 1'b0) begin n_err++; $display("FAIL trunc2_flag_clear: got %b want 0", trunc_flag); end
  endtask

  task automatic test_simultaneous_exit();
    // gate_s drops at edge 11, the same cycle as the 3rd strobe (ticks 3, 7, 11).
    decim = 8'd4; channels = 4'd1; max_samples = 16'd3;
    run_window(9, -1, -1, 8'd0);
    n_cmp++; if (stb_q.size() != 3) begin n_err++; $display("FAIL simul_nstrobe: got %0d want 3", stb_q.size()); end
    n_cmp++; if (last_stb != 11) begin n_err++; $display("FAIL simul_last_strobe: got %0d want 11", last_stb); end
    n_cmp++; if (ge_cnt != 9) begin n_err++; $display("FAIL simul_ge_span: got %0d want 9", ge_cnt); end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL simul_done_seen: got %0d want 0", done_cnt); end
    n_cmp++; if (trunc_flag !== 1'b0) begin n_err++; $display("FAIL simul_trunc: got %b want 0", trunc_flag); end
    n_cmp++; if (sample_count !== 16'd3) begin n_err++; $display("FAIL simul_sample_count: got %0d want 3", sample_count); end
    n_cmp++; if (window_count !== 16'd6) begin n_err++; $display("FAIL simul_window_count: got %0d want 6", window_count); end
  endtask

  task automatic test_mid_change_and_disable();
    decim = 8'd4; channels = 4'd1; max_samples = 16'd0;
    run_window(40, -1, 10, 8'd9);
    n_cmp++; if (stb_q.size() != 10) begin n_err++; $display("FAIL midchg_nstrobe: got %0d want 10", stb_q.size()); end
    n_cmp++; if (bad_gaps(4) != 0) begin n_err++; $display("FAIL midchg_period: got %0d bad gaps want 0", bad_gaps(4)); end
    n_cmp++; if (window_count !== 16'd7) begin n_err++; $display("FAIL midchg_window_count: got %0d want 7", window_count); end
    run_window(40, -1, -1, 8'd0);
    n_cmp++; if (stb_q.size() != 5) begin n_err++; $display("FAIL next_nstrobe: got %0d want 5", stb_q.size()); end
    n_cmp++; if (bad_gaps(9) != 0) begin n_err++; $display("FAIL next_period: got %0d bad gaps want 0", bad_gaps(9)); end
    n_cmp++; if (sample_count !== 16'd5) begin n_err++; $display("FAIL next_sample_count: got %0d want 5", sample_count); end
    enable = 1'b0;
    run_window(30, -1, -1, 8'd0);
    enable = 1'b1;
    n_cmp++; if (stb_q.size() != 0) begin n_err++; $display("FAIL dis_nstrobe: got %0d want 0", stb_q.size()); end
    n_cmp++; if (ge_cnt != 0) begin n_err++; $display("FAIL dis_ge_span: got %0d want 0", ge_cnt); end
    n_cmp++; if (window_count !== 16'd8) begin n_err++; $display("FAIL dis_window_count: got %0d want 8", window_count); end
    n_cmp++; if (sample_count !== 16'd5) begin n_err++; $display("FAIL dis_sample_hold: got %0d want 5", sample_count); end
  endtask

  task automatic test_reset_mid_window();
    decim = 8'd4; channels = 4'd1; max_samples = 16'd0;
    gate_in = 1'b1;
    repeat (11) tick();
    n_cmp++; if (strobe !== 1'b1) begin n_err++; $display("FAIL rmid_pre_strobe: got %b want 1", strobe); end
    n_cmp++; if (sample_count !== 16'd2) begin n_err++; $display("FAIL rmid_pre_count: got %0d want 2", sample_count); end
    n_cmp++; if (window_count !== 16'd9) begin n_err++; $display("FAIL rmid_pre_wcount: got %0d want 9", window_count); end
    reset = 1'b0;
    #1;
    n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL rmid_strobe: got %b want 0", strobe); end
    n_cmp++; if (gate_enable !== 1'b0) begin n_err++; $display("FAIL rmid_gate_enable: got %b want 0", gate_enable); end
    n_cmp++; if (sample_count !== 16'd0) begin n_err++; $display("FAIL rmid_sample_count: got %0d want 0", sample_count); end
    n_cmp++; if (window_count !== 16'd0) begin n_err++; $display("FAIL rmid_window_count: got %0d want 0", window_count); end
    n_cmp++; if (debugbus !== 16'h0000) begin n_err++; $display("FAIL rmid_debugbus: got %h want 0000", debugbus); end
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 3) begin
        n_cmp++; if (gate_enable !== 1'b0 || strobe !== 1'b0) begin n_err++; $display("FAIL rrel_early_%0d: got ge=%b stb=%b want 0 0", i, gate_enable, strobe); end
      end else if (i == 3) begin
        n_cmp++; if (strobe !== 1'b1 || gate_enable !== 1'b1) begin n_err++; $display("FAIL rrel_start: got ge=%b stb=%b want 1 1", gate_enable, strobe); end
        n_cmp++; if (window_count !== 16'd1) begin n_err++; $display("FAIL rrel_window_count: got %0d want 1", window_count); end
        n_cmp++; if (sample_count !== 16'd0) begin n_err++; $display("FAIL rrel_sample_start: got %0d want 0", sample_count); end
      end else begin
        n_cmp++; if (sample_count !== 16'd1) begin n_err++; $display("FAIL rrel_sample_next: got %0d want 1", sample_count); end
      end
    end
    gate_in = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_period_clamp();
    test_truncation();
    test_simultaneous_exit();
    test_mid_change_and_disable();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
